aclk_time_entry: RTL and testbench

AClk_TIME_ENTRY -- requirements
Module: aclk_time_entry

---
 rtl/aclk_pkg.sv | 32 +++
 rtl/aclk_entry_timer.sv | 35 +++
 rtl/aclk_time_entry.sv | 148 ++++++++++++++
 tb/tb_aclk_time_entry.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/aclk_pkg.sv
// Shared definitions for the alarm-clock time entry block: FSM state
// encoding, key codes, timeout length and the time-validity check.
package aclk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ENTRY = 2'd1,
    ST_READY = 2'd2
  } state_e;

  localparam logic [3:0]  KEY_CLEAR       = 4'hF;
  localparam logic [3:0]  KEY_MAX_DIGIT   = 4'd9;
  localparam logic [2:0]  DIGITS_FULL     = 3'd4;
  localparam int unsigned TIMEOUT_SECONDS = 10;

  function automatic logic is_digit(input logic [3:0] k);
    return k <= KEY_MAX_DIGIT;
  endfunction

  // HH:MM in 24-hour form, 00:00 .. 23:59
  function automatic logic valid_time(input logic [3:0] ms_hr,
                                      input logic [3:0] ls_hr,
                                      input logic [3:0] ms_min,
                                      input logic [3:0] ls_min);
    logic hr_ok;
    hr_ok = (ms_hr < 4'd2) ? (ls_hr <= 4'd9)
          : (ms_hr == 4'd2) ? (ls_hr <= 4'd3)
          : 1'b0;
    return hr_ok && (ms_min <= 4'd5) && (ls_min <= 4'd9);
  endfunction

endpackage

// File: rtl/aclk_entry_timer.sv
// Entry inactivity timer: counts one_second ticks while an entry is in
// progress and flags the tick that completes TIMEOUT_SECONDS.
module aclk_entry_timer
  import aclk_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic tick_i,
  output logic expired_o
);

  localparam logic [3:0] LAST_COUNT = 4'(TIMEOUT_SECONDS - 1);

  logic [3:0] cnt_q, cnt_d;

  // Next count: clear wins over tick, wrap to 0 on the expiring tick
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (tick_i) begin
      cnt_d = (cnt_q == LAST_COUNT) ? '0 : cnt_q + 4'd1;
    end
  end

  assign expired_o = tick_i && !clr_i && (cnt_q == LAST_COUNT);

  // Counter register
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/aclk_time_entry.sv
// Keypad time entry for the alarm clock: shifts four digits into a buffer
// and commits it as current time or alarm time on a button strobe.
// Optional feature macro: ACLK_ENTRY_TIMEOUT_EN (abandon entry after
// TIMEOUT_SECONDS one_second ticks without an accepted key).
module aclk_time_entry
  import aclk_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] key,
  input  logic       key_valid,
  input  logic       time_button,
  input  logic       alarm_button,
  input  logic       one_second,
  output logic [3:0] new_time_ms_hr,
  output logic [3:0] new_time_ls_hr,
  output logic [3:0] new_time_ms_min,
  output logic [3:0] new_time_ls_min,
  output logic       load_new_c,
  output logic       load_new_a,
  output logic       show_new_time,
  output logic       entry_err
);

  state_e     state_q, state_d;
  logic [2:0] count_q, count_d;
  logic [3:0] ms_hr_q, ms_hr_d, ls_hr_q, ls_hr_d;
  logic [3:0] ms_min_q, ms_min_d, ls_min_q, ls_min_d;
  logic       load_c_q, load_c_d, load_a_q, load_a_d, err_q, err_d;

  logic       digit_key, clear_key, button, timeout;
  logic [2:0] count_inc;

  assign digit_key = key_valid && is_digit(key);
  assign clear_key = key_valid && (key == KEY_CLEAR);
  assign button    = time_button || alarm_button;
  assign count_inc = (count_q >= DIGITS_FULL) ? DIGITS_FULL : count_q + 3'd1;

`ifdef ACLK_ENTRY_TIMEOUT_EN
  logic timer_clr;
  // Any event that ends or refreshes the entry restarts the timeout window
  assign timer_clr = (state_q == ST_IDLE) || button || clear_key || digit_key;

  aclk_entry_timer u_timer (
    .clk       (clk),
    .reset     (reset),
    .clr_i     (timer_clr),
    .tick_i    (one_second),
    .expired_o (timeout)
  );
`else
  logic unused_one_second;
  assign unused_one_second = one_second;
  assign timeout           = 1'b0;
`endif

  // Next-state, buffer and pulse logic; priority: button > clear > digit > timeout
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    ms_hr_d  = ms_hr_q;
    ls_hr_d  = ls_hr_q;
    ms_min_d = ms_min_q;
    ls_min_d = ls_min_q;
    load_c_d = 1'b0;
    load_a_d = 1'b0;
    err_d    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (digit_key) begin
          ms_hr_d  = '0;
          ls_hr_d  = '0;
          ms_min_d = '0;
          ls_min_d = key;
          count_d  = 3'd1;
          state_d  = ST_ENTRY;
        end
      end
      ST_ENTRY, ST_READY: begin
        if (button) begin
          if (state_q == ST_READY &&
              valid_time(ms_hr_q, ls_hr_q, ms_min_q, ls_min_q)) begin
            load_c_d = time_button;
            load_a_d = !time_button;
          end else begin
            err_d = 1'b1;
          end
          count_d = '0;
          state_d = ST_IDLE;
        end else if (clear_key || timeout) begin
          ms_hr_d  = '0;
          ls_hr_d  = '0;
          ms_min_d = '0;
          ls_min_d = '0;
          count_d  = '0;
          state_d  = ST_IDLE;
        end else if (digit_key) begin
          ms_hr_d  = ls_hr_q;
          ls_hr_d  = ms_min_q;
          ms_min_d = ls_min_q;
          ls_min_d = key;
          count_d  = count_inc;
          state_d  = (count_inc == DIGITS_FULL) ? ST_READY : ST_ENTRY;
        end
      end
      default: begin
        state_d = ST_IDLE;
        count_d = '0;
      end
    endcase
  end

  // State, buffer and pulse registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      ms_hr_q  <= '0;
      ls_hr_q  <= '0;
      ms_min_q <= '0;
      ls_min_q <= '0;
      load_c_q <= 1'b0;
      load_a_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      ms_hr_q  <= ms_hr_d;
      ls_hr_q  <= ls_hr_d;
      ms_min_q <= ms_min_d;
      ls_min_q <= ls_min_d;
      load_c_q <= load_c_d;
      load_a_q <= load_a_d;
      err_q    <= err_d;
    end
  end

  assign new_time_ms_hr  = ms_hr_q;
  assign new_time_ls_hr  = ls_hr_q;
  assign new_time_ms_min = ms_min_q;
  assign new_time_ls_min = ls_min_q;
  assign load_new_c      = load_c_q;
  assign load_new_a      = load_a_q;
  assign entry_err       = err_q;
  assign show_new_time   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_aclk_time_entry.sv
// Scoreboard bench for aclk_time_entry: a behavioural model predicts the
// buffer/display each cycle and queues expected commit pulses, which an
// independent monitor matches against the DUT's pulse outputs.
module tb_aclk_time_entry;

`ifdef ACLK_ENTRY_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] key = '0;
  logic       key_valid = 1'b0, time_button = 1'b0, alarm_button = 1'b0, one_second = 1'b0;
  logic [3:0] new_time_ms_hr, new_time_ls_hr, new_time_ms_min, new_time_ls_min;
  logic       load_new_c, load_new_a, show_new_time, entry_err;

  aclk_time_entry dut (
    .clk             (clk),
    .reset           (reset),
    .key             (key),
    .key_valid       (key_valid),
    .time_button     (time_button),
    .alarm_button    (alarm_button),
    .one_second      (one_second),
    .new_time_ms_hr  (new_time_ms_hr),
    .new_time_ls_hr  (new_time_ls_hr),
    .new_time_ms_min (new_time_ms_min),
    .new_time_ls_min (new_time_ls_min),
    .load_new_c      (load_new_c),
    .load_new_a      (load_new_a),
    .show_new_time   (show_new_time),
    .entry_err       (entry_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  // kind: 1 = load_new_c, 2 = load_new_a, 3 = entry_err
  typedef struct {
    int         kind;
    int         due;
    logic [15:0] digs;
  } exp_t;
  exp_t sbq[$];

  // Reference model: digit list (index 0 = tens of hours), entry active flag,
  // number of digits typed so far and seconds without a key.
  int  mb[4];
  bit  mact;
  int  mn;
  int  mtmo;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic bit model_valid();
    int hours;
    hours = mb[0] * 10 + mb[1];
    return (mb[0] <= 2) && (mb[1] <= 9) && (hours < 24) && (mb[2] <= 5) && (mb[3] <= 9);
  endfunction

  function automatic logic [15:0] model_digs();
    return {4'(mb[0]), 4'(mb[1]), 4'(mb[2]), 4'(mb[3])};
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 4; i++) mb[i] = 0;
  endtask

  // One clock: called at a falling edge, drives inputs, advances the model,
  // waits for the next falling edge and compares the visible buffer state.
  task automatic cycle(input bit r, input bit kv, input int k, input bit tb, input bit ab, input bit os);
    int kind;
    exp_t e;
    reset = r; key_valid = kv; key = 4'(k); time_button = tb; alarm_button = ab; one_second = os;
    kind = 0;
    if (r) begin
      model_clear(); mact = 0; mn = 0; mtmo = 0;
    end else if (!mact) begin
      if (kv && k <= 9) begin
        model_clear(); mb[3] = k; mn = 1; mact = 1; mtmo = 0;
      end
    end else if (tb || ab) begin
      if (mn >= 4 && model_valid()) kind = tb ? 1 : 2;
      else                          kind = 3;
      mact = 0; mn = 0;
    end else if (kv && k == 15) begin
      model_clear(); mact = 0; mn = 0;
    end else if (kv && k <= 9) begin
      mb[0] = mb[1]; mb[1] = mb[2]; mb[2] = mb[3]; mb[3] = k;
      mn = (mn >= 4) ? 4 : mn + 1;
      mtmo = 0;
    end else if (os && TMO_EN) begin
      mtmo++;
      if (mtmo == 10) begin
        model_clear(); mact = 0; mn = 0;
      end
    end
    if (!mact) mtmo = 0;
    if (kind != 0) begin
      e.kind = kind; e.due = cyc + 1; e.digs = model_digs();
      sbq.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
    check("buffer", 32'({new_time_ms_hr, new_time_ls_hr, new_time_ms_min, new_time_ls_min}),
          32'(model_digs()));
    check("show_new_time", 32'(show_new_time), 32'(mact));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0);
  endtask

  task automatic press(input int k);
    cycle(0, 1, k, 0, 0, 0);
  endtask

  // Monitor: every pulse the DUT presents must match the queue head
  always @(negedge clk) begin
    int   np;
    int   kind;
    exp_t e;
    np = int'(load_new_c) + int'(load_new_a) + int'(entry_err);
    if (np > 1) check("pulse_exclusive", 32'(np), 32'd1);
    if (np > 0) begin
      kind = load_new_c ? 1 : (load_new_a ? 2 : 3);
      if (sbq.size() == 0) begin
        check("unexpected_pulse", 32'(kind), 32'd0);
      end else begin
        e = sbq.pop_front();
        check("pulse_kind", 32'(kind), 32'(e.kind));
        check("pulse_cycle", 32'(cyc), 32'(e.due));
        check("pulse_digits",
              32'({new_time_ms_hr, new_time_ls_hr, new_time_ms_min, new_time_ls_min}),
              32'(e.digs));
      end
    end else if (sbq.size() != 0 && sbq[0].due <= cyc) begin
      e = sbq.pop_front();
      check("missing_pulse", 32'd0, 32'(e.kind));
    end
  end

  initial begin
    int k;
    bit r, kv, tb, ab, os;
    mact = 0; mn = 0; mtmo = 0;
    model_clear();
    @(negedge clk);
    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 1, 5, 1, 0, 1);
    idle(2);

    // 12:34 committed as time
    press(1); press(2); press(3); press(4); cycle(0, 0, 0, 1, 0, 0); idle(2);
    // 25:00 rejected
    press(2); press(5); press(0); press(0); cycle(0, 0, 0, 1, 0, 0); idle(2);
    // five digits, last four kept, committed as alarm
    press(1); press(2); press(3); press(4); press(5); cycle(0, 0, 0, 0, 1, 0); idle(2);
    // incomplete entry, then clear
    press(1); press(2); cycle(0, 0, 0, 1, 0, 0); idle(1);
    press(1); press(2); press(15); idle(2);
    // ignored keys and commands in idle
    press(11); press(15); cycle(0, 0, 0, 1, 1, 1); idle(1);
    // ten one_second ticks mid-entry
    press(1); press(2);
    for (int i = 0; i < 10; i++) begin cycle(0, 0, 0, 0, 0, 1); idle(1); end
    press(3); press(4); idle(1); press(15); idle(1);
    // both buttons together, key together with button
    press(2); press(3); press(5); press(9); cycle(0, 1, 7, 1, 1, 0); idle(2);
    // reset with a pending commit
    press(0); press(7); press(3); press(0); cycle(1, 0, 0, 1, 0, 0); idle(2);

    // random traffic
    for (int n = 0; n < 4000; n++) begin
      r  = ($urandom_range(0, 199) == 0);
      kv = ($urandom_range(0, 99) < 45);
      if ($urandom_range(0, 1) == 1) k = $urandom_range(0, 3);
      else                           k = $urandom_range(0, 15);
      tb = ($urandom_range(0, 99) < 6);
      ab = ($urandom_range(0, 99) < 6);
      os = ($urandom_range(0, 99) < 25);
      cycle(r, kv, k, tb, ab, os);
    end

    idle(3);
    check("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
